// File: rtl/weightbank_ctrl.sv
// weightbank_ctrl: sequencer for the skewed N-bank weight memory.
// It streams a weight load into the banks row by row, runs read sweeps over
// the stored rows, and keeps each operation busy until the bank skew
// pipeline has drained.
// Ports:
//   clk, rst         clock and asynchronous active-low reset
//   load_start       request a load burst (sampled only in IDLE, wins a tie)
//   run_start        request a read sweep (sampled only in IDLE)
//   cfg_len_m1       row count minus one, latched on the accepted start
//   load_valid       a row is present on the bank data input
//   load_ready       row accepted this cycle (LOAD only)
//   run_hold         freeze read issue for this cycle (RUN only)
//   wraddr, wren     bank-0 write address / enable
//   rdaddr           bank-0 read address
//   rd_valid/rd_last bank-0 q holds a valid row / the final row of the sweep
//   busy             not IDLE
//   load_done        pulse on the last write-drain cycle
//   run_done         pulse on the last read-drain cycle
module weightbank_ctrl #(
  parameter int unsigned N     = 40,
  parameter int unsigned NADDR = 9,
  parameter int unsigned RDLAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             run_start,
  input  logic [NADDR-1:0] cfg_len_m1,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             run_hold,
  output logic [NADDR-1:0] wraddr,
  output logic             wren,
  output logic [NADDR-1:0] rdaddr,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             busy,
  output logic             load_done,
  output logic             run_done
);

  // Write drain covers the full skew; read drain also covers the RAM latency.
  localparam int unsigned WDRAIN_LEN = N;
  localparam int unsigned RDRAIN_LEN = N - 1 + RDLAT;
  localparam int unsigned DMAX       = (WDRAIN_LEN > RDRAIN_LEN) ? WDRAIN_LEN : RDRAIN_LEN;
  localparam int unsigned CW         = $clog2(DMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WDRAIN = 3'd2,
    RUN    = 3'd3,
    RDRAIN = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NADDR-1:0] len_r;
  logic [CW-1:0]    drain_cnt;
  logic [RDLAT-1:0] vld_sr;
  logic [RDLAT-1:0] last_sr;

  logic accept;
  logic issue;
  logic wr_at_last;
  logic rd_at_last;
  logic wdrain_end;
  logic rdrain_end;

  assign wr_at_last = (wraddr == len_r);
  assign rd_at_last = (rdaddr == len_r);
  assign wdrain_end = (drain_cnt == CW'(WDRAIN_LEN - 1));
  assign rdrain_end = (drain_cnt == CW'(RDRAIN_LEN - 1));
  assign wren       = load_valid & load_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and state-decoded controls.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    load_ready = 1'b0;
    busy       = 1'b0;
    load_done  = 1'b0;
    run_done   = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end else if (run_start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        if (load_valid && wr_at_last) state_nxt = WDRAIN;
      end
      WDRAIN: begin
        busy = 1'b1;
        if (wdrain_end) begin
          load_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = ~run_hold;
        if (!run_hold && rd_at_last) state_nxt = RDRAIN;
      end
      RDRAIN: begin
        busy = 1'b1;
        if (rdrain_end) begin
          run_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Length latch and address counters; counters stop at len_r, never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r  <= '0;
      wraddr <= '0;
      rdaddr <= '0;
    end else if (accept) begin
      len_r  <= cfg_len_m1;
      wraddr <= '0;
      rdaddr <= '0;
    end else begin
      if (wren && !wr_at_last)  wraddr <= wraddr + NADDR'(1);
      if (issue && !rd_at_last) rdaddr <= rdaddr + NADDR'(1);
    end
  end

  // Drain counter runs only in the drain states and restarts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt <= '0;
    end else if (state == WDRAIN || state == RDRAIN) begin
      drain_cnt <= drain_cnt + CW'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // Read-latency delay line aligning valid/last with bank-0 q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= issue;
      last_sr[0] <= issue & rd_at_last;
      for (int i = 1; i < int'(RDLAT); i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign rd_valid = vld_sr[RDLAT-1];
  assign rd_last  = last_sr[RDLAT-1];

endmodule

// File: tb/tb_weightbank_ctrl.sv
// Scoreboard bench for weightbank_ctrl: stimulus predicts each output event
// (write beat, read row, done pulse) with its cycle stamp; a negedge monitor
// pops and compares whenever the DUT presents one.
module tb_weightbank_ctrl;

  localparam int N     = 40;
  localparam int NADDR = 9;
  localparam int RDLAT = 1;

  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_LD  = 2;
  localparam int EV_RDN = 3;

  typedef struct {
    int kind;
    int addr;
    int last;
    int cyc;
  } ev_t;

  logic             clk;
  logic             rst;
  logic             load_start;
  logic             run_start;
  logic [NADDR-1:0] cfg_len_m1;
  logic             load_valid;
  logic             load_ready;
  logic             run_hold;
  logic [NADDR-1:0] wraddr;
  logic             wren;
  logic [NADDR-1:0] rdaddr;
  logic             rd_valid;
  logic             rd_last;
  logic             busy;
  logic             load_done;
  logic             run_done;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  prev_rdaddr = 0;

  weightbank_ctrl #(.N(N), .NADDR(NADDR), .RDLAT(RDLAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .run_start  (run_start),
    .cfg_len_m1 (cfg_len_m1),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .run_hold   (run_hold),
    .wraddr     (wraddr),
    .wren       (wren),
    .rdaddr     (rdaddr),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .busy       (busy),
    .load_done  (load_done),
    .run_done   (run_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int addr, input int last, input int c);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.last = last;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Pop the oldest predicted event and compare against what the DUT shows.
  task automatic check_ev(input int kind, input int addr, input int last);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d addr=%0d last=%0d cycle=%0d expected none",
               kind, addr, last, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.addr != addr || e.last != last || e.cyc != cyc) begin
        errors++;
        $display("FAIL event actual kind=%0d addr=%0d last=%0d cycle=%0d expected kind=%0d addr=%0d last=%0d cycle=%0d",
                 kind, addr, last, cyc, e.kind, e.addr, e.last, e.cyc);
      end
    end
  endtask

  // Monitor: any visible output event must match the scoreboard head.
  always @(negedge clk) begin
    if (wren)      check_ev(EV_WR, int'(wraddr), 0);
    if (rd_valid)  check_ev(EV_RD, prev_rdaddr, int'(rd_last));
    else if (rd_last) chk("rd_last_without_valid", 1, 0);
    if (load_done) check_ev(EV_LD, 0, 0);
    if (run_done)  check_ev(EV_RDN, 0, 0);
    prev_rdaddr = int'(rdaddr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sb.size() == 0 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("drain_to_idle", int'(ok), 1);
    if (!ok) sb.delete();
  endtask

  function automatic int all_outs();
    return int'({load_ready, wren, wraddr, rdaddr, rd_valid, rd_last, busy, load_done, run_done});
  endfunction

  // Load burst of len+1 rows. pattern: valid sequence 1,0,1,1,...; both: run_start
  // raised together with load_start and held through LOAD.
  task automatic do_load(input int len, input bit both, input bit pattern);
    int k;
    int p;
    bit v;
    load_start = 1'b1;
    run_start  = both;
    cfg_len_m1 = NADDR'(len);
    step();
    load_start = 1'b0;
    k = 0;
    p = 0;
    forever begin
      chk("load_ready", int'(load_ready), 1);
      chk("busy_in_load", int'(busy), 1);
      v = pattern ? (p != 1) : ($urandom_range(0, 9) < 7);
      load_valid = v;
      if (v) begin
        push(EV_WR, k, 0, cyc);
        if (k == len) begin
          push(EV_LD, 0, 0, cyc + N);
          step();
          break;
        end
        k++;
      end
      p++;
      step();
    end
    load_valid = 1'b0;
    run_start  = 1'b0;
    wait_idle(N + 10);
  endtask

  // Read sweep of len+1 rows. hold_mode 0: none, 1: random, 2: hold the two
  // cycles after the first issue. abort_at >= 0 resets mid-sweep at that row.
  task automatic do_run(input int len, input int hold_mode, input int abort_at);
    int k;
    int p;
    bit h;
    run_start  = 1'b1;
    cfg_len_m1 = NADDR'(len);
    step();
    run_start = 1'b0;
    k = 0;
    p = 0;
    forever begin
      case (hold_mode)
        1:       h = ($urandom_range(0, 9) < 3);
        2:       h = (p == 1 || p == 2);
        default: h = 1'b0;
      endcase
      if (!h && k == abort_at) begin
        chk("rdaddr_before_reset", int'(rdaddr), k);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("outs_after_mid_reset", all_outs(), 0);
        sb.delete();
        repeat (3) step();
        rst = 1'b1;
        repeat (N + 5) step();
        chk("idle_after_mid_reset", int'(busy), 0);
        return;
      end
      run_hold = h;
      if (!h) begin
        push(EV_RD, k, int'(k == len), cyc + RDLAT);
        if (k == len) begin
          push(EV_RDN, 0, 0, cyc + N - 1 + RDLAT);
          step();
          break;
        end
        k++;
      end
      p++;
      step();
    end
    run_hold = 1'b0;
    wait_idle(N + 10);
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    run_start  = 1'b0;
    cfg_len_m1 = '0;
    load_valid = 1'b0;
    run_hold   = 1'b0;

    // Reset held with random inputs: every output stays low.
    for (int i = 0; i < 4; i++) begin
      load_start = 1'($urandom);
      run_start  = 1'($urandom);
      load_valid = 1'($urandom);
      run_hold   = 1'($urandom);
      cfg_len_m1 = NADDR'($urandom);
      step();
      chk("outs_in_reset", all_outs(), 0);
    end
    load_start = 1'b0;
    run_start  = 1'b0;
    load_valid = 1'b0;
    run_hold   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      step();
      chk("idle_after_reset", all_outs(), 0);
    end

    do_load(3, 1'b0, 1'b1);           // stalls 1,0,1,1,1
    do_run(511, 0, -1);               // full-depth sweep
    do_run(2, 2, -1);                 // two-cycle hold after first issue
    do_load(2, 1'b1, 1'b0);           // simultaneous start, run ignored in LOAD
    do_load(0, 1'b0, 1'b0);           // single row
    do_run(0, 0, -1);
    do_run(511, 0, 100);              // reset mid-sweep
    do_run(5, 0, -1);                 // fresh sweep restarts from row 0

    for (int i = 0; i < 10; i++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_load(len, 1'($urandom), 1'b0);
      else                           do_run(len, int'($urandom_range(0, 1)), -1);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
